// File: rtl/pwm_seq.sv
// rtl/pwm_seq.sv - APB-configured duty-cycle sequencer driving a PWM peripheral over APB
//
// Purpose: holds a table of PWM compare values and, once enabled, programs the
// PWM's DIV, COMP and STATE registers through a dedicated APB master port,
// stepping COMP through the table at a programmable interval (one-shot or loop).
//
// Ports:
//   apb_pclk, apb_prstn          clock, asynchronous active-low reset
//   apb_psel/penable/pwrite      slave control (no wait states)
//   apb_paddr, apb_pwdata        slave address (decode on [7:0]) and write data
//   apb_prdata                   slave read data, 0 outside a read strobe
//   m_psel/m_penable/m_pwrite    master control towards the PWM (m_pwrite tied 1)
//   m_paddr, m_pwdata            master address (PWM_BASE + offset) and write data
//   irq                          level interrupt, DONE & IE
module pwm_seq #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] PWM_BASE = 32'h0
) (
  input  logic        apb_pclk,
  input  logic        apb_prstn,
  input  logic        apb_psel,
  input  logic [31:0] apb_paddr,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata,
  output logic        irq
);

  localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH5 = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_DIV,
    S_W_COMP,
    S_W_START,
    S_WAIT,
    S_W_STOP
  } state_e;

  // Configuration registers
  logic        en_q, loop_q, ie_q;
  logic [31:0] div_q;
  logic [31:0] ival_q;
  logic [4:0]  len_q;
  logic [31:0] tbl_q [DEPTH];

  // Sequencer state
  state_e      state_q, state_d;
  logic        phase_q, phase_d;   // 0 = SETUP, 1 = ACCESS
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic        first_q, first_d;   // still on the first pass (START not yet written)
  logic        abort_q, abort_d;   // stop was caused by EN clear, so DONE stays 0
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hold_q;             // master write data captured at SETUP

  // Slave decode
  logic          wr_stb, rd_stb, start;
  logic [7:0]    off;
  logic          tbl_hit;
  logic [IW-1:0] tbl_idx;
  logic          unused_paddr;

  assign off          = apb_paddr[7:0];
  assign unused_paddr = ^apb_paddr[31:8];
  assign wr_stb       = apb_psel & apb_penable & apb_pwrite;
  assign rd_stb       = apb_psel & apb_penable & ~apb_pwrite;
  assign start        = wr_stb && (off == 8'h00) && apb_pwdata[0];
  // Table window 0x40..0x7C, word aligned, index below DEPTH
  assign tbl_hit      = (off[7:6] == 2'b01) && (off[1:0] == 2'b00) &&
                        ({1'b0, off[5:2]} < DEPTH5);
  assign tbl_idx      = off[IW+1:2];

  // Register file
  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      en_q   <= 1'b0;
      loop_q <= 1'b0;
      ie_q   <= 1'b0;
      div_q  <= '0;
      ival_q <= '0;
      len_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
    end else if (wr_stb) begin
      case (off)
        8'h00: begin
          en_q   <= apb_pwdata[0];
          loop_q <= apb_pwdata[1];
          ie_q   <= apb_pwdata[2];
        end
        8'h04:   div_q  <= apb_pwdata;
        8'h08:   ival_q <= apb_pwdata;
        8'h0C:   len_q  <= apb_pwdata[4:0];
        default: if (tbl_hit) tbl_q[tbl_idx] <= apb_pwdata;
      endcase
    end
  end

  // Read mux
  logic busy;
  assign busy = (state_q != S_IDLE);

  always_comb begin
    apb_prdata = '0;
    if (rd_stb) begin
      case (off)
        8'h00:   apb_prdata = {29'b0, ie_q, loop_q, en_q};
        8'h04:   apb_prdata = div_q;
        8'h08:   apb_prdata = ival_q;
        8'h0C:   apb_prdata = {27'b0, len_q};
        8'h10:   apb_prdata = {20'b0, idx_q, 6'b0, done_q, busy};
        default: if (tbl_hit) apb_prdata = tbl_q[tbl_idx];
      endcase
    end
  end

  // Effective interval/length: 0 means 1, LEN clamps to the table size
  logic [31:0] ival_m1;
  logic [4:0]  len_eff;
  logic        last_idx;
  assign ival_m1  = (ival_q == 32'd0) ? 32'd0 : ival_q - 32'd1;
  assign len_eff  = (len_q == 5'd0) ? 5'd1 : ((len_q > DEPTH5) ? DEPTH5 : len_q);
  assign last_idx = (({1'b0, idx_q} + 5'd1) >= len_eff);

  // Master transfer content for the current write state
  logic        in_xfer;
  logic [7:0]  xfer_off;
  logic [31:0] xfer_data;

  always_comb begin
    in_xfer   = 1'b0;
    xfer_off  = 8'h00;
    xfer_data = '0;
    case (state_q)
      S_W_DIV: begin
        in_xfer   = 1'b1;
        xfer_off  = 8'h30;
        xfer_data = div_q;
      end
      S_W_COMP: begin
        in_xfer   = 1'b1;
        xfer_off  = 8'h34;
        xfer_data = tbl_q[idx_q[IW-1:0]];
      end
      S_W_START: begin
        in_xfer   = 1'b1;
        xfer_off  = 8'h38;
        xfer_data = 32'd1;
      end
      S_W_STOP: begin
        in_xfer   = 1'b1;
        xfer_off  = 8'h38;
        xfer_data = 32'd0;
      end
      default: ;
    endcase
  end

  // SETUP drives the live value; ACCESS replays the captured one so a
  // register write landing during SETUP cannot change data mid-transfer.
  assign m_psel    = in_xfer;
  assign m_penable = in_xfer & phase_q;
  assign m_pwrite  = 1'b1;
  assign m_paddr   = in_xfer ? (PWM_BASE + {24'b0, xfer_off}) : 32'd0;
  assign m_pwdata  = in_xfer ? (phase_q ? hold_q : xfer_data) : 32'd0;
  assign irq       = done_q & ie_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    done_d  = done_q;
    first_d = first_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;

    if (start) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_W_DIV;
          phase_d = 1'b0;
          idx_d   = 4'd0;
          first_d = 1'b1;
          abort_d = 1'b0;
        end
      end
      S_W_DIV, S_W_COMP, S_W_START: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!en_q) begin
            state_d = S_W_STOP;
            abort_d = 1'b1;
          end else if (state_q == S_W_DIV) begin
            state_d = S_W_COMP;
          end else if (state_q == S_W_COMP && first_q) begin
            state_d = S_W_START;
            first_d = 1'b0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 32'd0;
          end
        end
      end
      S_WAIT: begin
        if (!en_q) begin
          state_d = S_W_STOP;
          phase_d = 1'b0;
          abort_d = 1'b1;
        end else if (cnt_q >= ival_m1) begin
          phase_d = 1'b0;
          if (!last_idx) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_W_COMP;
          end else if (loop_q) begin
            idx_d   = 4'd0;
            state_d = S_W_COMP;
          end else begin
            state_d = S_W_STOP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_W_STOP: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = S_IDLE;
          if (!abort_q) done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge apb_pclk or negedge apb_prstn) begin
    if (!apb_prstn) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      first_q <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      first_q <= first_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      if (in_xfer && !phase_q) hold_q <= xfer_data;
    end
  end

endmodule

// File: tb/tb_pwm_seq.sv
// tb/tb_pwm_seq.sv - self-checking bench for pwm_seq
module tb_pwm_seq;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_CTRL = 32'h00, A_DIV = 32'h04, A_INT = 32'h08;
  localparam logic [31:0] A_LEN = 32'h0C, A_STAT = 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pwm_seq #(.DEPTH(8), .PWM_BASE(BASE)) dut (
    .apb_pclk   (clk),
    .apb_prstn  (rst_n),
    .apb_psel   (psel),
    .apb_paddr  (paddr),
    .apb_penable(penable),
    .apb_pwrite (pwrite),
    .apb_pwdata (pwdata),
    .apb_prdata (prdata),
    .m_psel     (m_psel),
    .m_penable  (m_penable),
    .m_pwrite   (m_pwrite),
    .m_paddr    (m_paddr),
    .m_pwdata   (m_pwdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master-port monitor: records each completed write and flags protocol breaks
  logic [31:0] act_addr[$], act_data[$];
  int          act_cyc[$];
  int          proto_bad = 0;
  logic        su_seen = 1'b0;
  logic [31:0] su_addr, su_data;
  int          su_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      su_seen = 1'b0;
    end else begin
      if (m_pwrite !== 1'b1) proto_bad++;
      if (m_psel && !m_penable) begin
        su_seen = 1'b1;
        su_addr = m_paddr;
        su_data = m_pwdata;
        su_cyc  = cyc;
      end else if (m_psel && m_penable) begin
        if (!su_seen || su_addr !== m_paddr || su_data !== m_pwdata || su_cyc + 1 != cyc)
          proto_bad++;
        act_addr.push_back(m_paddr);
        act_data.push_back(m_pwdata);
        act_cyc.push_back(cyc);
        su_seen = 1'b0;
      end else begin
        if (m_penable !== 1'b0 || m_paddr !== 32'd0 || m_pwdata !== 32'd0) proto_bad++;
        su_seen = 1'b0;
      end
    end
  end

  // Reference model state
  logic [31:0] tbl_m [8];
  logic [31:0] exp_addr[$], exp_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1;
    check("prdata_setup_zero", prdata, 32'd0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    d = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    apb_read(a, r);
    check(tag, r, exp);
  endtask

  task automatic clear_act();
    act_addr.delete(); act_data.delete(); act_cyc.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic exp_push(input logic [31:0] off, input logic [31:0] d);
    exp_addr.push_back(BASE + off);
    exp_data.push_back(d);
  endtask

  function automatic int len_eff_m(input int len);
    if (len == 0) return 1;
    if (len > 8) return 8;
    return len;
  endfunction

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (act_addr.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_timeout"}, 32'(act_addr.size() >= n), 32'd1);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_count"}, 32'(act_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), act_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", tag, i), act_data[i], exp_data[i]);
    end
  endtask

  // COMP writes: START sits between the first two, otherwise WAIT + SETUP + ACCESS
  task automatic check_gaps(input string tag, input int ival);
    int cc[$];
    int ie;
    ie = (ival == 0) ? 1 : ival;
    for (int i = 0; i < act_addr.size(); i++)
      if (act_addr[i] == BASE + 32'h34) cc.push_back(act_cyc[i]);
    for (int k = 1; k < cc.size(); k++)
      check($sformatf("%s_gap%0d", tag, k), 32'(cc[k] - cc[k-1]), 32'((k == 1) ? ie + 4 : ie + 2));
  endtask

  task automatic run_oneshot(input string tag, input int len, input int ival,
                             input logic [31:0] div, input logic ie);
    int le;
    logic [31:0] r;
    le = len_eff_m(len);
    apb_write(A_DIV, div);
    apb_write(A_INT, 32'(ival));
    apb_write(A_LEN, 32'(len));
    for (int i = 0; i < 8; i++) apb_write(32'h40 + 32'(4 * i), tbl_m[i]);
    clear_act();
    exp_push(32'h30, div);
    exp_push(32'h34, tbl_m[0]);
    exp_push(32'h38, 32'd1);
    for (int i = 1; i < le; i++) exp_push(32'h34, tbl_m[i]);
    exp_push(32'h38, 32'd0);
    apb_write(A_CTRL, {29'b0, ie, 2'b01});
    wait_writes(tag, exp_addr.size(), 2000);
    repeat (3) @(negedge clk);
    compare_run(tag);
    check_gaps(tag, ival);
    apb_read(A_STAT, r);
    check({tag, "_status"}, r, (32'(le - 1) << 8) | 32'h2);
    check({tag, "_irq"}, {31'b0, irq}, {31'b0, ie});
  endtask

  task automatic rand_table();
    for (int i = 0; i < 8; i++) tbl_m[i] = $urandom;
  endtask

  initial begin
    logic [31:0] div_v;
    logic        found;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_psel", {31'b0, m_psel}, 32'd0);
    check("rst_m_penable", {31'b0, m_penable}, 32'd0);
    check("rst_m_pwrite", {31'b0, m_pwrite}, 32'd1);
    check("rst_m_paddr", m_paddr, 32'd0);
    check("rst_m_pwdata", m_pwdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("rst_status", A_STAT, 32'd0);
    read_check("rst_ctrl", A_CTRL, 32'd0);

    // Basic one-shot
    tbl_m = '{32'd10, 32'd20, 32'd30, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    run_oneshot("basic", 3, 5, 32'd100, 1'b1);

    // Boundary values
    rand_table();
    run_oneshot("len0_int0", 0, 0, $urandom, 1'b1);
    rand_table();
    run_oneshot("len31", 31, 0, $urandom, 1'b0);

    // Randomized one-shot runs
    for (int r = 0; r < 4; r++) begin
      rand_table();
      run_oneshot($sformatf("rand%0d", r), int'($urandom_range(0, 10)),
                  int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)));
    end

    // Slave read rules
    apb_write(32'h60, 32'hDEAD_BEEF);
    read_check("rd_beyond_tbl", 32'h60, 32'd0);
    read_check("rd_tbl0_no_alias", 32'h40, tbl_m[0]);
    read_check("rd_tbl1", 32'h44, tbl_m[1]);
    read_check("rd_tbl7", 32'h5C, tbl_m[7]);
    apb_write(32'h20, 32'd1234);
    read_check("rd_unmapped", 32'h20, 32'd0);
    apb_write(A_LEN, 32'hFFFF_FFE3);
    read_check("rd_len_bits", A_LEN, 32'h3);

    // Loop mode with live table update, then disable during WAIT
    tbl_m[0] = 32'd5; tbl_m[1] = 32'd9;
    apb_write(32'h40, 32'd5);
    apb_write(32'h44, 32'd9);
    apb_write(A_LEN, 32'd2);
    apb_write(A_INT, 32'd20);
    apb_write(A_DIV, 32'h55);
    clear_act();
    apb_write(A_CTRL, 32'h7);
    wait_writes("loop_a", 5, 500);
    apb_write(32'h44, 32'd77);
    read_check("loop_busy", A_STAT, 32'h001);
    wait_writes("loop_b", 6, 500);
    apb_write(A_CTRL, 32'h6);
    wait_writes("loop_c", 7, 500);
    repeat (3) @(negedge clk);
    exp_push(32'h30, 32'h55);
    exp_push(32'h34, 32'd5);
    exp_push(32'h38, 32'd1);
    exp_push(32'h34, 32'd9);
    exp_push(32'h34, 32'd5);
    exp_push(32'h34, 32'd77);
    exp_push(32'h38, 32'd0);
    compare_run("loop");
    read_check("loop_stop_status", A_STAT, 32'h100);
    check("loop_stop_irq", {31'b0, irq}, 32'd0);

    // Disable during W_COMP SETUP, then re-enable from IDX 0
    rand_table();
    div_v = $urandom;
    for (int i = 0; i < 8; i++) apb_write(32'h40 + 32'(4 * i), tbl_m[i]);
    apb_write(A_LEN, 32'd8);
    apb_write(A_INT, 32'd3);
    apb_write(A_DIV, div_v);
    clear_act();
    apb_write(A_CTRL, 32'h5);
    wait_writes("dis_a", 4, 500);
    repeat (3) @(negedge clk);
    apb_write(A_CTRL, 32'h4);
    wait_writes("dis_b", 6, 500);
    repeat (3) @(negedge clk);
    exp_push(32'h30, div_v);
    exp_push(32'h34, tbl_m[0]);
    exp_push(32'h38, 32'd1);
    exp_push(32'h34, tbl_m[1]);
    exp_push(32'h34, tbl_m[2]);
    exp_push(32'h38, 32'd0);
    compare_run("dis");
    read_check("dis_status", A_STAT, 32'h200);
    check("dis_irq", {31'b0, irq}, 32'd0);
    run_oneshot("reen", 8, 3, div_v, 1'b1);

    // Asynchronous reset during the DIV ACCESS cycle
    clear_act();
    apb_write(A_CTRL, 32'h5);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (m_psel && m_penable && m_paddr == BASE + 32'h30) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("arst_found_access", {31'b0, found}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_m_psel", {31'b0, m_psel}, 32'd0);
    check("arst_m_penable", {31'b0, m_penable}, 32'd0);
    check("arst_m_paddr", m_paddr, 32'd0);
    check("arst_m_pwdata", m_pwdata, 32'd0);
    check("arst_m_pwrite", {31'b0, m_pwrite}, 32'd1);
    check("arst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("arst_status", A_STAT, 32'd0);
    read_check("arst_div", A_DIV, 32'd0);
    read_check("arst_tbl0", 32'h40, 32'd0);
    repeat (5) @(negedge clk);
    check("arst_idle_m_psel", {31'b0, m_psel}, 32'd0);

    check("master_protocol", 32'(proto_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
